// File: rtl/dot_pkg.sv
// Shared constants and FSM encoding for the dot-product vector loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dot_pkg;

    localparam int DOT_DIM        = 10;
    localparam int DOT_A_WIDTH    = 16;
    localparam int DOT_B_WIDTH    = 16;
    localparam int DOT_RES_WIDTH  = 36;
    localparam int DOT_DP_LATENCY = 4;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } dot_state_e;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_stage.sv
// Serial-to-parallel staging: element idx_i lands in slice idx_i of a staging vector; load_i publishes it.
// Latency: vec_o updates on the edge that accepts the load (the element written that cycle is included).
// Backpressure: none; the caller gates wr_en_i/load_i.
// Ports: clk_i/rst_i (sync active-high), wr_en_i/idx_i/elem_i write one element,
//        load_i copies staging (with this cycle's write) to vec_o, vec_o holds otherwise.
module vec_stage
    import dot_pkg::*;
#(
    parameter int DIM   = DOT_DIM,
    parameter int W     = DOT_A_WIDTH,
    parameter int IDX_W = idx_width(DIM)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [W-1:0]       elem_i,
    input  logic               load_i,
    output logic [DIM*W-1:0]   vec_o
);

    logic [DIM*W-1:0] stage_q, stage_d;
    logic [DIM*W-1:0] vec_q, vec_d;

    always_comb begin
        stage_d = stage_q;
        if (wr_en_i) begin
            stage_d[int'(idx_i)*W +: W] = elem_i;
        end
        vec_d = vec_q;
        // Copy the post-write view so the final element is not a cycle late.
        if (load_i) begin
            vec_d = stage_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
            vec_q   <= '0;
        end else begin
            stage_q <= stage_d;
            vec_q   <= vec_d;
        end
    end

    assign vec_o = vec_q;

endmodule

// File: rtl/dot_vector_loader.sv
// Collects DIM (A,B) element pairs, presents them as packed vectors to a dotProduct unit, then hands back its result.
// Latency: VecValid the cycle after the DIM-th transfer; ResValid DP_LATENCY cycles later (+1 with result capture).
// Backpressure: InReady only in FILL; ResValid holds until ResReady, after which FILL resumes next edge.
// Ports: Clock/Reset (sync active-high); InValid/InReady/InA/InB element input; A/B/VecValid vector output;
//        DotProduct result input; ResValid/ResReady result handshake; ResData only with DOT_LOADER_RESULT_CAPTURE_EN.
// Optional feature macro: DOT_LOADER_RESULT_CAPTURE_EN (registers DotProduct into ResData, adds one cycle).
module dot_vector_loader
    import dot_pkg::*;
#(
    parameter int DIM          = DOT_DIM,
    parameter int A_DATA_WIDTH = DOT_A_WIDTH,
    parameter int B_DATA_WIDTH = DOT_B_WIDTH,
    parameter int RES_WIDTH    = DOT_RES_WIDTH,
    parameter int DP_LATENCY   = DOT_DP_LATENCY
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [A_DATA_WIDTH-1:0]   InA,
    input  logic [B_DATA_WIDTH-1:0]   InB,
    output logic [A_DATA_WIDTH*DIM-1:0] A,
    output logic [B_DATA_WIDTH*DIM-1:0] B,
    output logic                      VecValid,
    input  logic [RES_WIDTH-1:0]      DotProduct,
    output logic                      ResValid,
    input  logic                      ResReady
`ifdef DOT_LOADER_RESULT_CAPTURE_EN
    ,
    output logic [RES_WIDTH-1:0]      ResData
`endif
);

    localparam int IDX_W = idx_width(DIM);
    localparam int CNT_W = idx_width(DP_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    // Cycles spent in WAIT: the capture register needs the result one cycle
    // before RESULT, so the capture build waits one cycle longer.
`ifdef DOT_LOADER_RESULT_CAPTURE_EN
    localparam int WAIT_CYCLES = DP_LATENCY;
`else
    localparam int WAIT_CYCLES = DP_LATENCY - 1;
`endif

    dot_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_en;
    logic               load;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        InReady  = 1'b0;
        VecValid = 1'b0;
        ResValid = 1'b0;
        wr_en    = 1'b0;
        load     = 1'b0;
        case (state_q)
            FILL: begin
                InReady = 1'b1;
                if (InValid) begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        load    = 1'b1;
                        idx_d   = '0;
                        state_d = ISSUE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ISSUE: begin
                VecValid = 1'b1;
                if (WAIT_CYCLES == 0) begin
                    state_d = RESULT;
                end else begin
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // cnt_q holds the WAIT cycles remaining including this one.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESULT: begin
                ResValid = 1'b1;
                if (ResReady) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    vec_stage #(
        .DIM   (DIM),
        .W     (A_DATA_WIDTH),
        .IDX_W (IDX_W)
    ) u_stage_a (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .wr_en_i (wr_en),
        .idx_i   (idx_q),
        .elem_i  (InA),
        .load_i  (load),
        .vec_o   (A)
    );

    vec_stage #(
        .DIM   (DIM),
        .W     (B_DATA_WIDTH),
        .IDX_W (IDX_W)
    ) u_stage_b (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .wr_en_i (wr_en),
        .idx_i   (idx_q),
        .elem_i  (InB),
        .load_i  (load),
        .vec_o   (B)
    );

`ifdef DOT_LOADER_RESULT_CAPTURE_EN
    logic [RES_WIDTH-1:0] res_q, res_d;

    // Sample on the last WAIT cycle, which is cycle N+DP_LATENCY.
    always_comb begin
        res_d = res_q;
        if (state_q == WAIT && cnt_q <= CNT_W'(1)) begin
            res_d = DotProduct;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign ResData = res_q;
`else
    // Consumer reads DotProduct directly in this build.
    logic unused_dot_product;
    assign unused_dot_product = ^DotProduct;
`endif

endmodule

// File: tb/tb_dot_vector_loader.sv
`timescale 1ns/1ps
module tb_dot_vector_loader;

    localparam int DIM = 10;
    localparam int AW  = 16;
    localparam int BW  = 16;
    localparam int RW  = 36;
    localparam int LAT = 4;
`ifdef DOT_LOADER_RESULT_CAPTURE_EN
    localparam int CAP = 1;
`else
    localparam int CAP = 0;
`endif

    logic                Clock = 1'b0;
    logic                Reset = 1'b1;
    logic                InValid = 1'b0;
    logic                InReady;
    logic [AW-1:0]       InA = '0;
    logic [BW-1:0]       InB = '0;
    logic [AW*DIM-1:0]   A;
    logic [BW*DIM-1:0]   B;
    logic                VecValid;
    logic [RW-1:0]       DotProduct;
    logic                ResValid;
    logic                ResReady = 1'b0;
`ifdef DOT_LOADER_RESULT_CAPTURE_EN
    logic [RW-1:0]       ResData;
    logic [RW-1:0]       l1_res_data;
`endif

    // Second instance with the minimum pipeline latency.
    logic                l1_rst = 1'b1;
    logic                l1_iv = 1'b0;
    logic                l1_ir, l1_vv, l1_rv;
    logic [AW*DIM-1:0]   l1_a;
    logic [BW*DIM-1:0]   l1_b;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rst_seen = 1'b0;
    int   last_drive = 0;

    dot_vector_loader #(
        .DIM(DIM), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW), .RES_WIDTH(RW), .DP_LATENCY(LAT)
    ) u_dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .A(A), .B(B), .VecValid(VecValid),
        .DotProduct(DotProduct), .ResValid(ResValid), .ResReady(ResReady)
`ifdef DOT_LOADER_RESULT_CAPTURE_EN
        , .ResData(ResData)
`endif
    );

    dot_vector_loader #(
        .DIM(DIM), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW), .RES_WIDTH(RW), .DP_LATENCY(1)
    ) u_dut_lat1 (
        .Clock(Clock), .Reset(l1_rst), .InValid(l1_iv), .InReady(l1_ir),
        .InA(AW'(3)), .InB(BW'(2)), .A(l1_a), .B(l1_b), .VecValid(l1_vv),
        .DotProduct({RW{1'b0}}), .ResValid(l1_rv), .ResReady(1'b1)
`ifdef DOT_LOADER_RESULT_CAPTURE_EN
        , .ResData(l1_res_data)
`endif
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        cyc      = cyc + 1;
        rst_seen = Reset;
    end

    // Connected dotProduct unit: LAT-stage pipeline of the full dot product.
    logic [RW-1:0] dp_pipe [LAT];

    function automatic logic [RW-1:0] dot_of(input logic [AW*DIM-1:0] a, input logic [BW*DIM-1:0] b);
        logic [RW-1:0] s;
        s = '0;
        for (int k = 0; k < DIM; k++) s = s + RW'(a[k*AW +: AW]) * RW'(b[k*BW +: BW]);
        return s;
    endfunction

    always @(posedge Clock) begin
        dp_pipe[0] <= dot_of(A, B);
        for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign DotProduct = dp_pipe[LAT-1];

    typedef struct packed {
        logic [DIM-1:0][AW-1:0] a;
        logic [DIM-1:0][BW-1:0] b;
        logic [RW-1:0]          dot;
        int                     issue;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit            pending = 1'b0;
    bit            in_res = 1'b0;
    bit            hs_pend = 1'b0;
    bit            vv_prev = 1'b0;
    int            issue_c = 0;
    int            hold = 0;
    int            nres = 0;
    exp_t          cur;
    logic [RW-1:0] held;
    logic [RW-1:0] res_now;

    always @(negedge Clock) begin
`ifdef DOT_LOADER_RESULT_CAPTURE_EN
        res_now = ResData;
`else
        res_now = DotProduct;
`endif
        if (rst_seen) begin
            check("rst_inready", 64'(InReady), 64'(1));
            check("rst_vecvalid", 64'(VecValid), 64'(0));
            check("rst_resvalid", 64'(ResValid), 64'(0));
            check("rst_A_zero", 64'(|A), 64'(0));
            check("rst_B_zero", 64'(|B), 64'(0));
`ifdef DOT_LOADER_RESULT_CAPTURE_EN
            check("rst_resdata_zero", 64'(ResData), 64'(0));
`endif
            pending  = 1'b0;
            in_res   = 1'b0;
            hs_pend  = 1'b0;
            vv_prev  = 1'b0;
            ResReady = 1'($urandom);
        end else begin
            if (hs_pend) begin
                check("accept_resvalid_drop", 64'(ResValid), 64'(0));
                check("accept_back_to_fill", 64'(InReady), 64'(1));
                hs_pend = 1'b0;
                in_res  = 1'b0;
                pending = 1'b0;
            end
            if (VecValid) begin
                check("vecvalid_single_pulse", 64'(vv_prev), 64'(0));
                if (exp_q.size() == 0) begin
                    check("vecvalid_expected", 64'(1), 64'(0));
                end else begin
                    cur = exp_q.pop_front();
                    check("issue_cycle", 64'(cyc), 64'(cur.issue));
                    check("issue_inready_low", 64'(InReady), 64'(0));
                    for (int k = 0; k < DIM; k++) begin
                        check($sformatf("A_slice%0d", k), 64'(A[k*AW +: AW]), 64'(cur.a[k]));
                        check($sformatf("B_slice%0d", k), 64'(B[k*BW +: BW]), 64'(cur.b[k]));
                    end
                    pending = 1'b1;
                    issue_c = cyc;
                end
            end
            vv_prev = VecValid;
            if (ResValid) begin
                check("inready_low_in_result", 64'(InReady), 64'(0));
                if (!in_res) begin
                    if (!pending) begin
                        check("resvalid_expected", 64'(1), 64'(0));
                    end else begin
                        check("resvalid_latency", 64'(cyc - issue_c), 64'(LAT + CAP));
                        check("result_value", 64'(res_now), 64'(cur.dot));
                    end
                    held   = res_now;
                    in_res = 1'b1;
                    hold   = (nres == 1) ? 5 : $urandom_range(0, 3);
                    nres++;
                end else begin
                    check("result_stable", 64'(res_now), 64'(held));
                end
                ResReady = (hold == 0);
                if (hold > 0) hold--;
                if (ResReady) hs_pend = 1'b1;
            end else begin
                if (pending && !in_res && (cyc - issue_c) > LAT + CAP) begin
                    check("resvalid_timeout", 64'(0), 64'(1));
                    pending = 1'b0;
                end
                // Random ResReady outside RESULT must not disturb anything.
                ResReady = 1'($urandom);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_elem(input logic [AW-1:0] a, input logic [BW-1:0] b, input int gap);
        int waited;
        waited = 0;
        repeat (gap) begin
            @(negedge Clock);
            InValid = 1'b0;
            InA = AW'($urandom);
            InB = BW'($urandom);
        end
        forever begin
            @(negedge Clock);
            if (InReady) begin
                InValid = 1'b1;
                InA = a;
                InB = b;
                last_drive = cyc;
                return;
            end
            // Noise while the loader is busy; must be ignored.
            InValid = 1'($urandom);
            InA = AW'($urandom);
            InB = BW'($urandom);
            waited++;
            if (waited > 500) begin
                $display("FAIL inready_timeout: InReady low for %0d cycles, expected 1", waited);
                $fatal(1, "stuck");
            end
        end
    endtask

    task automatic send_vec(input logic [DIM-1:0][AW-1:0] a, input logic [DIM-1:0][BW-1:0] b,
                            input int mode, output int first_c);
        exp_t   e;
        longint s;
        int     g;
        first_c = 0;
        s = 0;
        for (int k = 0; k < DIM; k++) begin
            g = (mode == 0) ? 0 : (mode == 1) ? ((k == 0) ? 0 : 1) : $urandom_range(0, 2);
            drive_elem(a[k], b[k], g);
            if (k == 0) first_c = last_drive;
            s = s + longint'(a[k]) * longint'(b[k]);
        end
        e.a = a;
        e.b = b;
        e.dot = RW'(s);
        e.issue = last_drive + 1;
        exp_q.push_back(e);
    endtask

    logic [DIM-1:0][AW-1:0] va;
    logic [DIM-1:0][BW-1:0] vb;
    int fc;
    int budget;

    initial begin
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;

        for (int k = 0; k < DIM; k++) begin va[k] = AW'(8); vb[k] = BW'(8); end
        send_vec(va, vb, 0, fc);

        for (int k = 0; k < DIM; k++) begin va[k] = AW'(k + 1); vb[k] = BW'(1); end
        send_vec(va, vb, 0, fc);

        for (int k = 0; k < DIM; k++) begin va[k] = AW'($urandom); vb[k] = BW'($urandom); end
        send_vec(va, vb, 1, fc);
        check("toggle_fill_cycles", 64'(last_drive - fc + 1), 64'(19));

        // Partial vector aborted by reset after the 6th element.
        for (int k = 0; k < 6; k++) drive_elem(AW'($urandom), BW'($urandom), 0);
        @(negedge Clock);
        InValid = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;

        for (int k = 0; k < DIM; k++) begin va[k] = AW'(100 + k); vb[k] = BW'(2 * k + 1); end
        send_vec(va, vb, 0, fc);

        repeat (6) begin
            for (int k = 0; k < DIM; k++) begin va[k] = AW'($urandom); vb[k] = BW'($urandom); end
            send_vec(va, vb, 2, fc);
        end

        @(negedge Clock);
        InValid = 1'b0;
        budget = 0;
        while ((exp_q.size() != 0 || pending) && budget < 2000) begin
            @(negedge Clock);
            budget++;
        end
        check("drain_complete", 64'(budget < 2000), 64'(1));
        repeat (3) @(negedge Clock);

        // DP_LATENCY=1 instance: ISSUE goes straight to RESULT without capture.
        l1_rst = 1'b0;
        @(negedge Clock);
        for (int k = 0; k < DIM; k++) begin
            check("lat1_inready_fill", 64'(l1_ir), 64'(1));
            l1_iv = 1'b1;
            @(negedge Clock);
        end
        l1_iv = 1'b0;
        check("lat1_vecvalid", 64'(l1_vv), 64'(1));
        check("lat1_resvalid_at_issue", 64'(l1_rv), 64'(0));
        check("lat1_A_slice9", 64'(l1_a[9*AW +: AW]), 64'(3));
        @(negedge Clock);
        check("lat1_resvalid_n1", 64'(l1_rv), 64'(CAP == 0 ? 1 : 0));
        check("lat1_inready_busy", 64'(l1_ir), 64'(0));
        if (CAP == 1) begin
            @(negedge Clock);
            check("lat1_resvalid_n2", 64'(l1_rv), 64'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
